// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the hazard unit: scoreboard entry layout,
// forwarding-select encoding and the select-width helper.
package hazard_unit_pkg;

    // Register-address field is sized for the widest supported REG_AW (up to 8).
    localparam int unsigned RD_W          = 8;
    localparam int unsigned FWD_SEL_RF    = 0;
    localparam int unsigned FWD_SEL_SLOT0 = 1;

    typedef struct packed {
        logic            v;
        logic [RD_W-1:0] rd;
        logic            ld;
    } sb_entry_t;

    function automatic int unsigned sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_unit_match.sv
// hazard_match: per-operand comparison of one decode source against every
// scoreboard slot, priority-encoded so the youngest (lowest-index) match wins.
module hazard_match
    import hazard_unit_pkg::*;
#(
    parameter int unsigned  REG_AW = 5,
    parameter int unsigned  DEPTH  = 3,
    localparam int unsigned SW     = sel_width(DEPTH)
) (
    input  logic [DEPTH-1:0]  slot_v_i,
    input  logic [RD_W-1:0]   slot_rd_i [DEPTH],
    input  logic              use_i,
    input  logic [REG_AW-1:0] src_i,
    output logic [SW-1:0]     sel_o
);

    logic [DEPTH-1:0] match_s;

    // Match vector, then a descending scan so slot 0 overrides older slots.
    always_comb begin
        match_s = '0;
        sel_o   = SW'(FWD_SEL_RF);
        for (int k = 0; k < DEPTH; k++) begin
            match_s[k] = use_i & (src_i != '0) & slot_v_i[k] & (slot_rd_i[k] == RD_W'(src_i));
        end
        for (int k = DEPTH - 1; k >= 0; k--) begin
            sel_o = match_s[k] ? SW'(k + 1) : sel_o;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: RAW hazard stall and forwarding-select generation over a DEPTH-slot
// scoreboard. Define HAZARD_FWD_EN for forwarding; otherwise every RAW hazard stalls.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned  REG_AW = 5,
    parameter int unsigned  DEPTH  = 3,
    parameter int unsigned  CNT_W  = 16,
    localparam int unsigned SW     = sel_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs,
    input  logic [REG_AW-1:0] dec_rt,
    input  logic              dec_use_rs,
    input  logic              dec_use_rt,
    input  logic              dec_wr_en,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [SW-1:0]     fwd_a_sel,
    output logic [SW-1:0]     fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    sb_entry_t        sb_q [DEPTH];
    sb_entry_t        sb_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [DEPTH-1:0] slot_v_s;
    logic [RD_W-1:0]  slot_rd_s [DEPTH];
    logic [SW-1:0]    sel_a_s;
    logic [SW-1:0]    sel_b_s;
    logic             hit_s;

    // Flatten the scoreboard into the fields the comparators need.
    always_comb begin
        slot_v_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_v_s[k]  = sb_q[k].v;
            slot_rd_s[k] = sb_q[k].rd;
        end
    end

    hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH)) u_match_a (
        .slot_v_i  (slot_v_s),
        .slot_rd_i (slot_rd_s),
        .use_i     (dec_use_rs),
        .src_i     (dec_rs),
        .sel_o     (sel_a_s)
    );

    hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH)) u_match_b (
        .slot_v_i  (slot_v_s),
        .slot_rd_i (slot_rd_s),
        .use_i     (dec_use_rt),
        .src_i     (dec_rt),
        .sel_o     (sel_b_s)
    );

    // Hazard decision and operand-source selection for the decode instruction.
    always_comb begin
        hit_s     = 1'b0;
        stall     = 1'b0;
        fwd_a_sel = SW'(FWD_SEL_RF);
        fwd_b_sel = SW'(FWD_SEL_RF);
`ifdef HAZARD_FWD_EN
        // Only a load still in EX is unforwardable; sel==slot0 means slot 0 is the youngest match.
        hit_s = sb_q[0].ld & ((sel_a_s == SW'(FWD_SEL_SLOT0)) | (sel_b_s == SW'(FWD_SEL_SLOT0)));
        if (dec_valid) begin
            fwd_a_sel = sel_a_s;
            fwd_b_sel = sel_b_s;
        end else begin
            fwd_a_sel = SW'(FWD_SEL_RF);
            fwd_b_sel = SW'(FWD_SEL_RF);
        end
`else
        hit_s = (sel_a_s != SW'(FWD_SEL_RF)) | (sel_b_s != SW'(FWD_SEL_RF));
`endif
        stall = dec_valid & ~flush & hit_s;
    end

    // Next scoreboard: decode enters slot 0 unless stalled or flushed; older slots age by one.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            sb_d[k] = '0;
        end
        if (!stall && !flush) begin
            sb_d[0].v  = dec_valid & dec_wr_en & (dec_rd != '0);
            sb_d[0].rd = RD_W'(dec_rd);
            sb_d[0].ld = dec_is_load;
        end else begin
            sb_d[0] = '0;
        end
        for (int k = 1; k < DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= sb_d[k];
            end
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; expectations come from a small
// reference model queued per step plus hand-derived constants for each scenario.
module tb_hazard_unit;

    localparam int DEPTH = 3;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dec_valid, dec_use_rs, dec_use_rt, dec_wr_en, dec_is_load, flush;
    logic [4:0] dec_rs, dec_rt, dec_rd;
    logic       stall, stall2;
    logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a_sel2, fwd_b_sel2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(5), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_wr_en(dec_wr_en), .dec_rd(dec_rd),
        .dec_is_load(dec_is_load), .flush(flush), .stall(stall), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
    );

    hazard_unit #(.REG_AW(5), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_wr_en(dec_wr_en), .dec_rd(dec_rd),
        .dec_is_load(dec_is_load), .flush(flush), .stall(stall2), .fwd_a_sel(fwd_a_sel2),
        .fwd_b_sel(fwd_b_sel2), .stall_cnt(stall_cnt2)
    );

    typedef struct packed {
        logic       v;
        logic       urs;
        logic [4:0] rs;
        logic       urt;
        logic [4:0] rt;
        logic       wr;
        logic [4:0] rd;
        logic       ld;
    } ins_t;

    typedef struct {
        logic        stall;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   nchk  = 0;
    int   npass = 0;

    logic        m_v  [DEPTH];
    logic [4:0]  m_rd [DEPTH];
    logic        m_ld [DEPTH];
    logic [15:0] m_cnt;
    logic [1:0]  m_cnt2;

    function automatic ins_t mk(input logic v, input logic urs, input logic [4:0] rs,
                                input logic urt, input logic [4:0] rt, input logic wr,
                                input logic [4:0] rd, input logic ld);
        ins_t r;
        r.v = v; r.urs = urs; r.rs = rs; r.urt = urt; r.rt = rt; r.wr = wr; r.rd = rd; r.ld = ld;
        return r;
    endfunction

    function automatic ins_t alu(input logic [4:0] rd);
        return mk(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, rd, 1'b0);
    endfunction

    function automatic ins_t ldw(input logic [4:0] rd);
        return mk(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, rd, 1'b1);
    endfunction

    function automatic ins_t idle();
        return mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_v[k] = 1'b0; m_rd[k] = 5'd0; m_ld[k] = 1'b0;
        end
        m_cnt  = 16'd0;
        m_cnt2 = 2'd0;
    endfunction

    // Youngest matching slot per operand; stall rule depends on whether forwarding exists.
    function automatic void model_eval(input ins_t in, input logic fl, output logic st,
                                       output logic [1:0] sa, output logic [1:0] sb);
        int ka = -1;
        int kb = -1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (in.urs && in.rs != 5'd0 && m_v[k] && m_rd[k] == in.rs) ka = k;
            if (in.urt && in.rt != 5'd0 && m_v[k] && m_rd[k] == in.rt) kb = k;
        end
        if (FWD) begin
            st = in.v && !fl && ((ka == 0 || kb == 0) && m_ld[0]);
            sa = (in.v && ka >= 0) ? 2'(ka + 1) : 2'd0;
            sb = (in.v && kb >= 0) ? 2'(kb + 1) : 2'd0;
        end else begin
            st = in.v && !fl && (ka >= 0 || kb >= 0);
            sa = 2'd0;
            sb = 2'd0;
        end
    endfunction

    function automatic void model_update(input ins_t in, input logic fl, input logic st);
        if (st) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
        end
        for (int k = DEPTH - 1; k >= 1; k--) begin
            m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
        end
        m_v[0]  = !st && !fl && in.v && in.wr && (in.rd != 5'd0);
        m_rd[0] = in.rd;
        m_ld[0] = in.ld;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input ins_t in, input logic fl);
        dec_valid = in.v; dec_use_rs = in.urs; dec_rs = in.rs; dec_use_rt = in.urt;
        dec_rt = in.rt; dec_wr_en = in.wr; dec_rd = in.rd; dec_is_load = in.ld; flush = fl;
    endtask

    // One decode cycle: drive at negedge, queue the model's expectation, compare before the edge.
    task automatic step(input string tag, input ins_t in, input logic fl, output logic o_st,
                        output logic [1:0] o_a, output logic [1:0] o_b, output logic e_st);
        exp_t e;
        exp_t got;
        drive(in, fl);
        model_eval(in, fl, e.stall, e.a, e.b);
        e.cnt = m_cnt; e.cnt2 = m_cnt2; e.tag = tag;
        sbq.push_back(e);
        #1;
        got = sbq.pop_front();
        chk({got.tag, ".stall"}, stall, got.stall);
        chk({got.tag, ".sel_a"}, fwd_a_sel, got.a);
        chk({got.tag, ".sel_b"}, fwd_b_sel, got.b);
        chk({got.tag, ".cnt"}, stall_cnt, got.cnt);
        chk({got.tag, ".cnt_sat"}, stall_cnt2, got.cnt2);
        chk({got.tag, ".stall_sat"}, stall2, got.stall);
        o_st = stall; o_a = fwd_a_sel; o_b = fwd_b_sel; e_st = e.stall;
        @(posedge clk);
        model_update(in, fl, e.stall);
        @(negedge clk);
    endtask

    // Present an instruction and hold it in decode while the model says it must stall.
    task automatic issue(input string tag, input ins_t in, output int nst,
                         output logic [1:0] a0, output logic [1:0] b0,
                         output logic [1:0] af, output logic [1:0] bf);
        logic       s, es;
        logic [1:0] a, b;
        nst = 0; a0 = 2'd0; b0 = 2'd0; af = 2'd0; bf = 2'd0;
        for (int i = 0; i < 8; i++) begin
            step(tag, in, 1'b0, s, a, b, es);
            if (i == 0) begin a0 = a; b0 = b; end
            if (s === 1'b1) nst++;
            af = a; bf = b;
            if (!es) break;
        end
    endtask

    task automatic drain(input int n);
        logic       s, es;
        logic [1:0] a, b;
        for (int i = 0; i < n; i++) step("idle", idle(), 1'b0, s, a, b, es);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nst;
        logic [1:0] a0, b0, af, bf, a, b;
        logic       s, es;

        model_reset();
        rst_n = 1'b0;
        drive(mk(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1), 1'b0);
        #2;
        chk("reset.stall", stall, 0);
        chk("reset.sel_a", fwd_a_sel, 0);
        chk("reset.sel_b", fwd_b_sel, 0);
        chk("reset.cnt", stall_cnt, 0);
        chk("reset.cnt_sat", stall_cnt2, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU result reused immediately
        issue("alu_r5", alu(5'd5), nst, a0, b0, af, bf);
        issue("use_rs_r5", mk(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), nst, a0, b0, af, bf);
        chk("alu_use.stall_cycles", nst, FWD ? 0 : 3);
        chk("alu_use.sel_a", a0, FWD ? 1 : 0);
        step("invalid_dec", mk(1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0), 1'b0, s, a, b, es);
        chk("invalid_dec.stall", s, 0);
        chk("invalid_dec.sel_a", a, 0);
        drain(3);

        // Load result reused immediately
        issue("ld_r7", ldw(5'd7), nst, a0, b0, af, bf);
        issue("use_rt_r7", mk(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0), nst, a0, b0, af, bf);
        chk("load_use.stall_cycles", nst, FWD ? 1 : 3);
        chk("load_use.sel_b_after", bf, FWD ? 2 : 0);
        #1;
        chk("load_use.cnt", stall_cnt, FWD ? 1 : 6);
        drain(3);

        // Two writers of r3; the youngest must win on both operands
        issue("alu_r3_old", alu(5'd3), nst, a0, b0, af, bf);
        issue("alu_r9", alu(5'd9), nst, a0, b0, af, bf);
        issue("alu_r3_new", alu(5'd3), nst, a0, b0, af, bf);
        issue("use_both_r3", mk(1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0), nst, a0, b0, af, bf);
        chk("youngest.stall_cycles", nst, FWD ? 0 : 3);
        chk("youngest.sel_a", a0, FWD ? 1 : 0);
        chk("youngest.sel_b", b0, FWD ? 1 : 0);
        drain(3);

        // r0 is never a hazard
        issue("alu_r0", alu(5'd0), nst, a0, b0, af, bf);
        issue("use_r0", mk(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0), nst, a0, b0, af, bf);
        chk("r0.stall_cycles", nst, 0);
        chk("r0.sel_a", a0, 0);
        chk("r0.sel_b", b0, 0);
        drain(1);

        // Flush beats stall and leaves a bubble: the flushed writer of r6 must not be tracked
        issue("ld_r4", ldw(5'd4), nst, a0, b0, af, bf);
        step("flush_use_r4", mk(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0), 1'b1, s, a, b, es);
        chk("flush.stall", s, 0);
        issue("use_r6", mk(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), nst, a0, b0, af, bf);
        chk("flush_bubble.stall_cycles", nst, 0);
        chk("flush_bubble.sel_a", a0, 0);
        drain(3);

        // Reset asserted in the middle of a stall
        issue("ld_r8", ldw(5'd8), nst, a0, b0, af, bf);
        drive(mk(1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), 1'b0);
        #1;
        chk("pre_reset.stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset.stall", stall, 0);
        chk("mid_reset.cnt", stall_cnt, 0);
        chk("mid_reset.cnt_sat", stall_cnt2, 0);
        chk("mid_reset.sel_a", fwd_a_sel, 0);
        chk("mid_reset.sel_b", fwd_b_sel, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Five load-use pairs: the 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            issue("sat_ld", ldw(5'(10 + i)), nst, a0, b0, af, bf);
            issue("sat_use", mk(1'b1, 1'b1, 5'(10 + i), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), nst, a0, b0, af, bf);
            chk("sat_pair.stall_cycles", nst, FWD ? 1 : 3);
        end
        #1;
        chk("sat.cnt_main", stall_cnt, FWD ? 5 : 15);
        chk("sat.cnt_sat", stall_cnt2, 3);
        issue("alu_r2", alu(5'd2), nst, a0, b0, af, bf);
        issue("use_rt_r2", mk(1'b1, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0), nst, a0, b0, af, bf);
        chk("alu_use2.sel_b", b0, FWD ? 1 : 0);
        #1;
        chk("sat_hold.cnt_main", stall_cnt, FWD ? 5 : 18);
        chk("sat_hold.cnt_sat", stall_cnt2, 3);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked in-flight stages after decode (slot 0 = EX ... slot DEPTH-1 = WB); legal range 1..7.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock, rising edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- dec_valid, in, 1, decode holds a real instruction.
- dec_rs, in, REG_AW, decode source A.
- dec_rt, in, REG_AW, decode source B.
- dec_use_rs, in, 1, instruction reads rs.
- dec_use_rt, in, 1, instruction reads rt.
- dec_wr_en, in, 1, instruction writes a register.
- dec_rd, in, REG_AW, destination register.
- dec_is_load, in, 1, result available only from slot 1 onward.
- flush, in, 1, kill the decode instruction (branch redirect).
- stall, out, 1, hold fetch and decode this cycle.
- fwd_a_sel, out, SW = clog2(DEPTH+1), operand A source: 0 = register file, k+1 = slot k.
- fwd_b_sel, out, SW, same for operand B.
- stall_cnt, out, CNT_W, saturating count of stall cycles.

Function
REQ-005 SHALL hold a DEPTH-entry scoreboard shift register; each entry = {v, rd, ld}.
REQ-006 Every rising edge, entry k SHALL move to k+1; entry DEPTH-1 SHALL be discarded.
REQ-007 Slot 0 SHALL load {dec_valid & dec_wr_en & (dec_rd != 0), dec_rd, dec_is_load} when stall = 0 and flush = 0; otherwise SHALL load a bubble (v = 0).
REQ-008 A source matches slot k when it is used, is nonzero, and equals a valid slot's rd.
REQ-009 stall SHALL be combinational, same cycle: 1 when dec_valid, flush = 0, and a used source matches slot 0 with ld = 1.
REQ-010 fwd_x_sel SHALL be k+1 for the lowest-index (youngest) matching slot, or 0 when there is no match; register 0 SHALL always select 0.
REQ-011 A load in slot k >= 1 SHALL be forwardable like any other slot.
REQ-012 With dec_valid = 0, stall SHALL be 0 and both sels SHALL be 0.
REQ-013 flush SHALL take priority over stall: stall = 0 and a bubble is inserted.
REQ-014 stall_cnt SHALL increment by 1 on each edge where stall = 1, and SHALL saturate at all-ones without wrap-around.
REQ-015 A stall SHALL last exactly one cycle per load-use pair, because the load advances to slot 1 on the next edge.

Reset
REQ-016 On rst_n = 0, all entries SHALL have v = 0 and stall_cnt SHALL be 0, immediately and without a clock.
REQ-017 During reset, stall = 0 and fwd_a_sel = fwd_b_sel = 0.
REQ-018 Reset asserted mid-stall SHALL drop stall asynchronously.
REQ-019 The first edge after rst_n rises SHALL capture normally.

Configuration
REQ-020 With macro HAZARD_FWD_EN defined, REQ-009 and REQ-010 apply (forwarding enabled).
REQ-021 Without HAZARD_FWD_EN:
- fwd_a_sel and fwd_b_sel SHALL be tied to 0.
- stall SHALL assert whenever a used source matches any valid slot, regardless of ld.
- the decode instruction is held until the writer leaves slot DEPTH-1.

Structure
REQ-022 A shared package SHALL hold the scoreboard-entry typedef {v, rd, ld}, the SW computation, and the named constant FWD_SEL_RF = 0.
REQ-023 The block SHALL instantiate one sub-module, hazard_match, used twice (once per source); it computes the match vector and the priority-encoded sel for one operand.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- ALU writes r5, next instruction reads rs = r5 -> no stall, fwd_a_sel = 1.
- Load writes r7, next instruction reads rt = r7 -> stall = 1 for one cycle, then fwd_b_sel = 2, stall_cnt = 1.
- Writes to r3 in slots 0 and 2, reader uses r3 on both operands -> fwd_a_sel = fwd_b_sel = 1 (youngest wins).
- Writer rd = r0, reader uses r0 -> sels = 0, no stall.
- Load-use hazard with flush = 1 in the same cycle -> stall = 0 and a bubble enters slot 0; rst_n low mid-stall -> stall = 0 and stall_cnt = 0 at once.
- CNT_W = 2 with 5 consecutive load-use pairs -> stall_cnt = 3 and holds there; without HAZARD_FWD_EN and DEPTH = 3, ALU-use -> stall for 3 cycles, sels = 0.
